// File: rtl/serial_complement_ctrl.sv
// serial_complement_ctrl
//   Bit-serial two's-complement negation. A single complement cell
//   (invert, xor with carry, and with carry) walks the zero-extended
//   operand LSB first, one bit per clock, and builds a WIDTH+1-bit result
//   equal to (2^(WIDTH+1) - x) mod 2^(WIDTH+1).
//
// Handshake:
//   start is sampled only while busy=0 (IDLE or DONE state). The edge that
//   accepts start latches x and raises busy. WIDTH+1 edges later, result and
//   zero are updated and done pulses high for exactly one cycle. A start seen
//   on the DONE edge is accepted immediately, so back-to-back operations
//   complete every WIDTH+2 cycles. A start seen while busy=1 is dropped.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   start   operation request
//   x       unsigned operand (WIDTH bits), latched on acceptance
//   busy    high while bits are being processed
//   done    one-cycle pulse when result/zero are updated
//   result  registered WIDTH+1-bit negation of x
//   zero    registered; high when the last result is all zeros
//
// The FSM state is held in the signal 'state' so that checkers can bind to it.
module serial_complement_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH:0]  op;
    logic [WIDTH:0]  work;
    logic            carry;
    logic [CW-1:0]   count;

    // Complement cell and the work value after this edge's shift.
    logic            inv_bit;
    logic            bit_out;
    logic            carry_next;
    logic [WIDTH:0]  work_next;

    always_comb begin
        inv_bit    = ~op[0];
        bit_out    = inv_bit ^ carry;
        carry_next = inv_bit & carry;
        work_next  = {bit_out, work[WIDTH:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= '0;
            work   <= '0;
            carry  <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Carry-in of 1 supplies the "+1" of invert-and-add-one.
                        op    <= {1'b0, x};
                        work  <= '0;
                        carry <= 1'b1;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work  <= work_next;
                    op    <= {1'b0, op[WIDTH:1]};
                    carry <= carry_next;
                    count <= count + 1'b1;
                    // Last bit: the carry out of bit WIDTH is simply dropped.
                    if (count == CW'(WIDTH)) begin
                        result <= work_next;
                        zero   <= (work_next == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_complement_ctrl.sv
// Testbench for serial_complement_ctrl (WIDTH=6).
// Expected {zero, result} pairs are pushed when an operation is driven and
// popped by a monitor on each done pulse. Outputs are sampled on the falling
// edge; inputs are driven on the falling edge.
module tb_serial_complement_ctrl;

    localparam int WIDTH = 6;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] x;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;
    logic             zero;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH:0]   last_res;

    serial_complement_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp_v);
    endtask

    // Reference: {zero, (2^(WIDTH+1) - x) mod 2^(WIDTH+1)}
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] xv);
        logic [WIDTH+1:0] full;
        logic [WIDTH:0]   r;
        full = (WIDTH+2)'(1 << (WIDTH+1)) - {2'b00, xv};
        r    = full[WIDTH:0];
        return {(xv == '0), r};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [WIDTH+1:0] e;
        if (reset) begin
            last_res = result;
        end else begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(result), 32'(e[WIDTH:0]));
                    check("zero", 32'(zero), 32'(e[WIDTH+1]));
                end
            end else begin
                check("result_stable", 32'(result), 32'(last_res));
            end
            last_res = result;
        end
    end

    // ---------------- driver tasks ----------------
    // One complete operation with a single-cycle start pulse.
    task automatic run_op(input logic [WIDTH-1:0] xv);
        int cyc;
        int busy_n;
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        exp_q.push_back(model(xv));
        @(negedge clk);
        start  = 1'b0;
        cyc    = 0;
        busy_n = 0;
        while (!done && cyc < 30) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_len", 32'(busy_n), 32'd7);
        check("busy_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
    endtask

    // Waits (bounded) for the next done, returning negedges elapsed.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 30);
        check("done_seen", 32'(done), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int d0;
        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        reset = 1'b0;

        // 1: single op, x=1
        run_op(6'b000001);

        // 2: sequential ops
        run_op(6'b000110);
        run_op(6'b100000);
        run_op(6'b111111);

        // 3: x=0
        run_op(6'b000000);

        // 4: start held high, x changes mid-run
        @(negedge clk);
        x     = 6'b000011;
        start = 1'b1;
        exp_q.push_back(model(6'b000011));
        repeat (3) @(negedge clk);
        check("busy_mid_run", 32'(busy), 32'd1);
        x = 6'b101010;
        exp_q.push_back(model(6'b101010));
        wait_done(cyc);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("held_done2", 32'(done), 32'd1);
        check("held_spacing", 32'(cyc), 32'd8);
        @(negedge clk);
        check("held_no_third", 32'(done), 32'd0);

        // 5: reset during the 4th RUN cycle
        @(negedge clk);
        x     = 6'b000101;
        start = 1'b1;
        exp_q.push_back(model(6'b000101));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        #1;
        check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
        run_op(6'b000101);

        // 6: exhaustive back-to-back sweep
        @(negedge clk);
        #1;
        d0    = done_cnt;
        x     = 6'd0;
        start = 1'b1;
        exp_q.push_back(model(6'd0));
        for (int i = 1; i < 64; i++) begin
            wait_done(cyc);
            check("sweep_spacing", 32'(cyc), 32'd8);
            x = 6'(i);
            exp_q.push_back(model(6'(i)));
        end
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("sweep_last_spacing", 32'(cyc), 32'd8);
        repeat (3) @(negedge clk);
        #1;
        check("sweep_dones", 32'(done_cnt - d0), 32'd64);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_complement_ctrl.md
Name: serial_complement_ctrl

Overview:
- Bit-serial two's-complement negation unit with a start/done handshake.
- Time-multiplexes a single complement cell (not / xor / and with a carry register) over the bits of an operand, LSB first, one bit per clock.
- Produces the WIDTH+1-bit two's complement of the zero-extended operand.
- Replaces the unrolled ripple chain where area matters more than latency.

Parameters:
- WIDTH, 6: operand width in bits. Result is WIDTH+1 bits. Must be >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- x  input  WIDTH  operand, unsigned; latched when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH+1  registered result; (2^(WIDTH+1) - x) mod 2^(WIDTH+1).
- zero  output  1  registered; high when the last result is all zeros (x was 0).

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, result=0, zero=1.
  - Internal shift register, carry and bit counter cleared.
  - Any in-progress operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch x into operand shift register (WIDTH+1 bits, MSB zero-filled).
  - Set carry=1, count=0, clear the work register, go RUN.
  - start=0: stay in IDLE.
- RUN, per edge:
  - b = ~op[0]; bit_out = b ^ carry; carry_next = b & carry.
  - Work register shifts right, with bit_out inserted at MSB.
  - op shifts right with 0 fill; count increments.
- RUN exit: after WIDTH+1 bit-edges (count reaches WIDTH), the final edge:
  - copies the completed work value into result;
  - sets zero = (completed value == 0);
  - goes to DONE.
- result and zero change only on that copy edge and on reset. They are stable at all other times, including during RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - start=1 on this edge is accepted exactly as in IDLE, going to RUN with the new x. Otherwise go to IDLE.
- Latency: done is high in the cycle beginning WIDTH+1 edges after the edge that accepted start.
  - Throughput: one operation per WIDTH+2 cycles with back-to-back start.
- busy:
  - 1 in RUN, 0 in IDLE and DONE.
  - Registered, so busy rises on the edge that accepts start.
- Boundary conditions:
  - start asserted while busy=1: ignored; no queueing.
  - x changing during RUN: no effect; the operand was latched at acceptance.
  - Final carry out of bit WIDTH: discarded (modulo 2^(WIDTH+1)).
  - x=0: result=0 and zero=1.
  - Any non-zero x: result MSB = 1.
  - x = 2^(WIDTH-1) (e.g. 100000): result = 2^(WIDTH+1) - 2^(WIDTH-1); no overflow exists in WIDTH+1 bits.
- Purely synchronous datapath apart from reset; no combinational path from inputs to outputs.

Test Plan (WIDTH=6):
1. Reset low, pulse start one cycle with x=000001:
   - busy high for 7 cycles, then done=1 for one cycle;
   - result=1111111, zero=0;
   - result unchanged before the done cycle.
2. Sequential ops x=000110, then 100000, then 111111, each started after the previous done:
   - results 1111010, 1100000, 1000001; zero=0 each time.
3. x=000000:
   - result=0000000, zero=1, done after 7 busy cycles.
4. Start x=000011 with start held high continuously; change x to 101010 mid-RUN:
   - first result 1111101 (x change ignored);
   - new op accepted on the DONE edge with x=101010;
   - second result 1010110 one op-period (8 cycles) after the first done.
5. Assert reset on the 4th RUN cycle of x=000101, then release:
   - immediately busy=0, done=0, result=0000000, zero=1;
   - no done pulse afterwards;
   - a new start x=000101 yields 1111011.
6. Exhaustive sweep of x=0..63 via back-to-back starts:
   - each result equals (128 - x) mod 128;
   - zero=1 only for x=0;
   - exactly one done per start, spaced 8 cycles apart.
